if_prefetch_queue: RTL and testbench
====================================

// Module: if_prefetch_queue
// PURPOSE
//  Instruction prefetch front end feeding the IF/ID pipeline register: issues sequential
//  fetches to instruction memory over a valid/ready request channel, buffers in-order
//  responses in a DEPTH-entry FIFO, presents head word + PC to IF2ID, flushes on taken
//  branch from ID, and holds its output while the hazard unit freezes the front end.
// PARAMETERS
//  WORD_LEN   32  instruction/address width (`WORD_LEN from defines.v)
//  DEPTH      4   queue entries; also the max in-flight + buffered words (power of 2)
//  PC_RESET   0   first fetch address after reset
// PORTS
//  clk             in   1         clock; all state on rising edge
//  rst             in   1         asynchronous, active-low reset (0 = reset)
//  imem_req_valid  out  1         fetch request valid
//  imem_req_ready  in   1         memory accepts request this cycle
//  imem_req_addr   out  WORD_LEN  fetch byte address (word aligned)
//  imem_rsp_valid  in   1         response word valid (in request order, >=1 cycle later)
//  imem_rsp_data   in   WORD_LEN  response instruction
//  freeze          in   1         hazard stall: do not pop head
//  branch_taken    in   1         ID-stage taken branch: flush and redirect
//  branch_target   in   WORD_LEN  redirect byte address
//  inst_valid      out  1         head entry valid
//  instruction     out  WORD_LEN  head instruction; `NOP (32'h0) when !inst_valid
//  PC              out  WORD_LEN  head instruction address + 4 (IF-stage PC convention)
// BEHAVIOUR
//  - Reset (rst=0, async): fetch_pc=PC_RESET, queue empty, inflight=0, drop=0;
//    imem_req_valid=0, inst_valid=0, instruction=0, PC=0. First request cycle after release.
//  - Credit rule: imem_req_valid = !branch_taken && (count + inflight < DEPTH).
//    Request fires on valid&&ready: fetch_pc += 4, inflight++. Address held stable while
//    valid&&!ready.
//  - Response: rsp_valid with drop>0 -> discard, drop--. Else push {addr+4, data} into
//    FIFO, inflight--. Push never overflows (guaranteed by credit rule; assert).
//  - Pop: head consumed on rising edge when inst_valid && !freeze && !branch_taken.
//  - Latency: request accepted cycle N, response cycle N+1 -> inst_valid at N+2.
//    No bypass from imem_rsp to output. Sustained 1 inst/cycle with 1-cycle memory.
//  - Flush (branch_taken=1, priority over everything): FIFO emptied, fetch_pc=branch_target,
//    drop = inflight (+1 if a request fires this cycle: cannot, req_valid is gated)
//    minus 1 if a non-dropped response arrives this same cycle (that response discarded
//    too); inflight=0. First target request issued the following cycle.
//  - branch_taken while freeze=1: flush still happens (branch wins over freeze).
//  - Empty: inst_valid=0, instruction=`NOP, PC holds last value. Full: req_valid=0.
//  - Pushing and popping in the same cycle when full is legal; count unchanged.
//  - fetch_pc wraps modulo 2^WORD_LEN; branch_target[1:0] ignored (forced 2'b00).
//  - Reset mid-operation: all state cleared immediately; responses to pre-reset requests
//    are the memory's responsibility (memory is reset by the same rst).
// STRUCTURE
//  - defines.v: `WORD_LEN, `NOP, `PC_INC (4). No new package.
//  - One sub-module: prefetch_fifo (sync FIFO, width 2*WORD_LEN, DEPTH; push/pop/flush,
//    count, full/empty; async active-low reset). Top holds fetch_pc, inflight, drop counters
//    ($clog2(DEPTH)+1 bits each) and handshake logic.
// TESTING
//  1 Reset then 1-cycle memory, ready=1, no freeze -> addrs 0,4,8,...; inst_valid first at
//    cycle 2; PC outputs 4,8,12,... one per cycle.
//  2 imem_req_ready=0 for 5 cycles -> req_valid stays 1, addr stable at 0x0; no entries.
//  3 freeze=1 for 6 cycles, memory ready -> 4 entries fill, req_valid drops (count=4),
//    instruction/PC unchanged; release -> pops resume, one per cycle.
//  4 3-cycle-latency memory, branch_taken with 2 in flight, target 0x100 -> two stale
//    responses discarded, next inst_valid word has PC=0x104.
//  5 branch_taken coincident with rsp_valid and freeze=1 -> response dropped, queue empty
//    next cycle, next request addr = target.
//  6 rst asserted mid-stream -> all outputs 0 asynchronously; fetch restarts at PC_RESET.

Source files
------------

// File: rtl/if_prefetch_queue_pkg.sv
// Shared constants for the instruction prefetch front end.
package if_prefetch_queue_pkg;

    localparam int DEF_WORD_LEN = 32;
    localparam int DEF_DEPTH    = 4;
    // Byte distance between consecutive instruction words.
    localparam int PC_INC       = 4;

    // Occupancy = buffered words plus words still owed by memory.
    function automatic int unsigned occupancy(input int unsigned count, input int unsigned inflight);
        return count + inflight;
    endfunction

endpackage

// File: rtl/if_prefetch_queue_chk.sv
// Protocol checker for the prefetch queue: the credit rule must keep the FIFO from overflowing.
module if_prefetch_queue_chk (
    input logic clk,
    input logic rst_n,
    input logic push_i,
    input logic pop_i,
    input logic full_i
);

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full_i && !pop_i))
        else $error("prefetch FIFO push while full without pop");

endmodule

// File: rtl/if_prefetch_queue_fifo.sv
// Synchronous FIFO holding {pc, instruction} entries; head is visible combinationally from storage.
module if_prefetch_queue_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push_s, do_pop_s;

    assign empty_o = (count_q == CW'(0));
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A full FIFO may still accept a push when the head leaves on the same edge.
    assign do_push_s = push_i && !flush_i && (!full_o || pop_i);
    assign do_pop_s  = pop_i && !flush_i && !empty_o;

    // Pointer and occupancy next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_s) wr_ptr_d = wr_ptr_q + AW'(1); else wr_ptr_d = wr_ptr_q;
            if (do_pop_s)  rd_ptr_d = rd_ptr_q + AW'(1); else rd_ptr_d = rd_ptr_q;
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer, count and storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push_s) mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch front end: credit-limited sequential fetch, in-order response buffer,
// branch flush with stale-response dropping, and freeze-aware head presentation to IF/ID.
module if_prefetch_queue
    import if_prefetch_queue_pkg::*;
#(
    parameter int                  WORD_LEN = DEF_WORD_LEN,
    parameter int                  DEPTH    = DEF_DEPTH,
    parameter logic [WORD_LEN-1:0] PC_RESET = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [WORD_LEN-1:0] imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [WORD_LEN-1:0] imem_rsp_data,
    input  logic                freeze,
    input  logic                branch_taken,
    input  logic [WORD_LEN-1:0] branch_target,
    output logic                inst_valid,
    output logic [WORD_LEN-1:0] instruction,
    output logic [WORD_LEN-1:0] PC
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [WORD_LEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [WORD_LEN-1:0]   pc_hold_q, pc_hold_d;
    logic [CW-1:0]         inflight_q, inflight_d;
    logic [CW-1:0]         drop_q, drop_d;

    logic [2*WORD_LEN-1:0] fifo_wdata_s, fifo_rdata_s;
    logic [CW-1:0]         fifo_count_s;
    logic                  fifo_full_s, fifo_empty_s;
    logic                  credit_s, req_valid_s, req_fire_s;
    logic                  rsp_keep_s, rsp_drop_s, push_s, pop_s;
    logic [WORD_LEN-1:0]   rsp_pc_s, head_pc_s, head_inst_s;

    assign credit_s    = occupancy(int'(fifo_count_s), int'(inflight_q)) < DEPTH;
    assign req_valid_s = rst && !branch_taken && credit_s;
    assign req_fire_s  = req_valid_s && imem_req_ready;

    assign rsp_keep_s  = imem_rsp_valid && (drop_q == CW'(0));
    assign rsp_drop_s  = imem_rsp_valid && (drop_q != CW'(0));
    // All kept in-flight words are sequential from the last redirect, so the oldest one sits
    // inflight words behind fetch_pc; stored PC is its address plus one word.
    assign rsp_pc_s    = fetch_pc_q - WORD_LEN'({inflight_q, 2'b00}) + WORD_LEN'(PC_INC);

    assign push_s       = rsp_keep_s && !branch_taken;
    assign pop_s        = !fifo_empty_s && !freeze && !branch_taken;
    assign fifo_wdata_s = {rsp_pc_s, imem_rsp_data};
    assign head_pc_s    = fifo_rdata_s[2*WORD_LEN-1:WORD_LEN];
    assign head_inst_s  = fifo_rdata_s[WORD_LEN-1:0];

    if_prefetch_queue_fifo #(
        .WIDTH (2*WORD_LEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .flush_i (branch_taken),
        .wdata_i (fifo_wdata_s),
        .rdata_o (fifo_rdata_s),
        .count_o (fifo_count_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    if_prefetch_queue_chk u_chk (
        .clk    (clk),
        .rst_n  (rst),
        .push_i (push_s),
        .pop_i  (pop_s),
        .full_i (fifo_full_s)
    );

    // Fetch pointer, credit and drop bookkeeping; a taken branch overrides everything.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        pc_hold_d  = pc_hold_q;
        if (branch_taken) begin
            fetch_pc_d = {branch_target[WORD_LEN-1:2], 2'b00};
            inflight_d = '0;
            // Any response arriving now is discarded as well, so it no longer counts.
            drop_d     = drop_q + inflight_q - CW'(imem_rsp_valid);
        end else begin
            if (req_fire_s) fetch_pc_d = fetch_pc_q + WORD_LEN'(PC_INC);
            else            fetch_pc_d = fetch_pc_q;
            inflight_d = inflight_q + CW'(req_fire_s) - CW'(rsp_keep_s);
            drop_d     = drop_q - CW'(rsp_drop_s);
        end
        if (fifo_empty_s) pc_hold_d = pc_hold_q;
        else              pc_hold_d = head_pc_s;
    end

    // Front-end state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= PC_RESET;
            pc_hold_q  <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pc_hold_q  <= pc_hold_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = fetch_pc_q;
    assign inst_valid     = !fifo_empty_s;
    assign instruction    = fifo_empty_s ? '0 : head_inst_s;
    assign PC             = fifo_empty_s ? pc_hold_q : head_pc_s;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue with a small in-order latency memory model.
module tb_if_prefetch_queue;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        inst_valid;
    logic [31:0] instruction;
    logic [31:0] PC;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t pend[$];
    int    cyc;
    int    lat;
    int    n_cmp;
    int    n_err;

    if_prefetch_queue dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .freeze         (freeze),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .inst_valid     (inst_valid),
        .instruction    (instruction),
        .PC             (PC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: present due response, record accepted request, end on the next falling edge.
    task automatic tick();
        logic        fire;
        logic [31:0] fa;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        #1;
        fire = imem_req_valid && imem_req_ready;
        fa   = imem_req_addr;
        @(posedge clk);
        cyc++;
        if (imem_rsp_valid) void'(pend.pop_front());
        if (fire) pend.push_back('{fa, cyc + lat - 1});
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        freeze         = 1'b0;
        branch_taken   = 1'b0;
        branch_target  = 32'h0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        lat            = 1;
        pend.delete();
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
    endtask

    initial begin
        bit seen;
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        lat   = 1;
        rst            = 1'b0;
        freeze         = 1'b0;
        branch_taken   = 1'b0;
        branch_target  = 32'h0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;

        // Test 1: reset state, then streaming with 1-cycle memory
        @(negedge clk);
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_instruction", instruction, 32'h0);
        chk("rst_pc", PC, 32'h0);
        rst = 1'b1;
        cyc = 0;
        #1;
        chk("t1_first_req", {31'b0, imem_req_valid}, 32'd1);
        chk("t1_first_addr", imem_req_addr, 32'h0);
        tick();
        chk("t1_c1_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("t1_c1_addr", imem_req_addr, 32'h4);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t1_inst_valid", {31'b0, inst_valid}, 32'd1);
            chk("t1_pc", PC, 32'(4 * (k + 1)));
            chk("t1_instr", instruction, mem_word(32'(4 * k)));
        end

        // Test 2: memory not ready holds request and address
        do_reset();
        imem_req_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t2_req_valid", {31'b0, imem_req_valid}, 32'd1);
            chk("t2_addr", imem_req_addr, 32'h0);
            chk("t2_inst_valid", {31'b0, inst_valid}, 32'd0);
        end
        imem_req_ready = 1'b1;
        tick();
        tick();
        chk("t2_after_ready_valid", {31'b0, inst_valid}, 32'd1);
        chk("t2_after_ready_pc", PC, 32'h4);

        // Test 3: freeze fills the queue, release pops one per cycle
        do_reset();
        freeze = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k >= 1) chk("t3_frozen_pc", PC, 32'h4);
        end
        chk("t3_full_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("t3_frozen_instr", instruction, mem_word(32'h0));
        freeze = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("t3_pop_valid", {31'b0, inst_valid}, 32'd1);
            chk("t3_pop_pc", PC, 32'(4 * (k + 1)));
            chk("t3_pop_instr", instruction, mem_word(32'(4 * k)));
        end

        // Test 4: 3-cycle memory, branch with two requests outstanding
        do_reset();
        lat = 3;
        tick();
        tick();
        branch_taken  = 1'b1;
        branch_target = 32'h100;
        #1;
        chk("t4_req_gated", {31'b0, imem_req_valid}, 32'd0);
        tick();
        branch_taken = 1'b0;
        #1;
        chk("t4_target_req", {31'b0, imem_req_valid}, 32'd1);
        chk("t4_target_addr", imem_req_addr, 32'h100);
        chk("t4_empty_after_flush", {31'b0, inst_valid}, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (inst_valid) seen = 1'b1;
        end
        chk("t4_inst_seen", {31'b0, seen}, 32'd1);
        chk("t4_first_pc", PC, 32'h104);
        chk("t4_first_instr", instruction, mem_word(32'h100));

        // Test 5: branch with response arriving and freeze set; unaligned target
        do_reset();
        freeze = 1'b1;
        tick();
        tick();
        tick();
        branch_taken  = 1'b1;
        branch_target = 32'h202;
        #1;
        chk("t5_req_gated", {31'b0, imem_req_valid}, 32'd0);
        tick();
        branch_taken = 1'b0;
        freeze       = 1'b0;
        #1;
        chk("t5_flushed_valid", {31'b0, inst_valid}, 32'd0);
        chk("t5_flushed_instr", instruction, 32'h0);
        chk("t5_pc_held", PC, 32'h4);
        chk("t5_target_addr", imem_req_addr, 32'h200);
        chk("t5_target_req", {31'b0, imem_req_valid}, 32'd1);
        tick();
        chk("t5_c5_valid", {31'b0, inst_valid}, 32'd0);
        tick();
        chk("t5_c6_valid", {31'b0, inst_valid}, 32'd1);
        chk("t5_c6_pc", PC, 32'h204);
        chk("t5_c6_instr", instruction, mem_word(32'h200));

        // Test 6: reset asserted mid-stream
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("t6_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("t6_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("t6_instr", instruction, 32'h0);
        chk("t6_pc", PC, 32'h0);
        chk("t6_addr", imem_req_addr, 32'h0);
        pend.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
        #1;
        chk("t6_restart_req", {31'b0, imem_req_valid}, 32'd1);
        chk("t6_restart_addr", imem_req_addr, 32'h0);
        tick();
        tick();
        chk("t6_restart_valid", {31'b0, inst_valid}, 32'd1);
        chk("t6_restart_pc", PC, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
